// File: rtl/dram_req_arbiter_if.sv
// Client and DRAM-controller signal bundle for dram_req_arbiter.
// The arbiter uses the slave modport; the client/controller side uses master.
interface dram_req_arbiter_if;
    // read clients: pixel feeder (pf) and graphics command fetch (gp)
    logic         pf_req;
    logic [30:0]  pf_addr;
    logic         pf_ack;
    logic         pf_rd_valid;
    logic         gp_req;
    logic [30:0]  gp_addr;
    logic         gp_ack;
    logic         gp_rd_valid;
    logic [127:0] rd_data;

    // write clients: frame filler (ff) and line engine (le)
    logic         ff_req;
    logic [30:0]  ff_addr;
    logic [255:0] ff_wdata;
    logic [31:0]  ff_wmask;
    logic         ff_ack;
    logic         le_req;
    logic [30:0]  le_addr;
    logic [255:0] le_wdata;
    logic [31:0]  le_wmask;
    logic         le_ack;

    // DRAM controller FIFOs
    logic         af_full;
    logic         af_wr_en;
    logic [30:0]  af_addr_din;
    logic [2:0]   af_cmd_din;
    logic         wdf_full;
    logic         wdf_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         rdf_valid;
    logic [127:0] rdf_dout;
    logic         rdf_rd_en;

    modport master (
        output pf_req, pf_addr, gp_req, gp_addr,
        output ff_req, ff_addr, ff_wdata, ff_wmask,
        output le_req, le_addr, le_wdata, le_wmask,
        output af_full, wdf_full, rdf_valid, rdf_dout,
        input  pf_ack, pf_rd_valid, gp_ack, gp_rd_valid, rd_data,
        input  ff_ack, le_ack,
        input  af_wr_en, af_addr_din, af_cmd_din,
        input  wdf_wr_en, wdf_din, wdf_mask_din, rdf_rd_en
    );

    modport slave (
        input  pf_req, pf_addr, gp_req, gp_addr,
        input  ff_req, ff_addr, ff_wdata, ff_wmask,
        input  le_req, le_addr, le_wdata, le_wmask,
        input  af_full, wdf_full, rdf_valid, rdf_dout,
        output pf_ack, pf_rd_valid, gp_ack, gp_rd_valid, rd_data,
        output ff_ack, le_ack,
        output af_wr_en, af_addr_din, af_cmd_din,
        output wdf_wr_en, wdf_din, wdf_mask_din, rdf_rd_en
    );
endinterface

// File: rtl/dram_req_arbiter.sv
// Four-client DRAM request arbiter: pf has absolute priority, gp/ff/le round-robin,
// writes issue as two-beat bursts, read beats are steered by an in-order tag queue.
module dram_req_arbiter #(
    parameter int TAG_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    dram_req_arbiter_if.slave  bus,
    output logic               o_orphan_err
);
    localparam int AW = $clog2(TAG_DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WR_B1 = 1'b1;

    localparam logic [1:0] RR_GP = 2'd0;
    localparam logic [1:0] RR_FF = 2'd1;
    localparam logic [1:0] RR_LE = 2'd2;
    localparam logic [2:0] RR_IS_WRITE = 3'b110;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam logic [AW:0] TAG_FULL_COUNT = (AW+1)'(TAG_DEPTH);

    logic [0:0]    r_state;
    logic [1:0]    r_rr_ptr;
    logic          r_wr_id;
    logic          r_tags [TAG_DEPTH];
    logic [AW-1:0] r_tag_wr_ptr;
    logic [AW-1:0] r_tag_rd_ptr;
    logic [AW:0]   r_tag_count;
    logic          r_beat;
    logic          r_orphan;

    logic          w_run;
    logic          w_idle;
    logic          w_rd_ok;
    logic          w_wr_ok;
    logic [2:0]    w_rr_req;
    logic [2:0]    w_rr_elig;
    logic [1:0]    w_rr_idx1;
    logic [1:0]    w_rr_idx2;
    logic          w_rr_hit;
    logic [1:0]    w_rr_win;
    logic          w_pf_go;
    logic          w_rr_go;
    logic          w_gp_go;
    logic          w_ff_go;
    logic          w_le_go;
    logic          w_wr_go;
    logic          w_push;
    logic          w_b1_go;
    logic          w_rdf_pop;
    logic          w_tag_busy;
    logic          w_tag_head;
    logic          w_tag_pop;

    function automatic logic [1:0] rr_add(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Every output is gated by the reset so the port goes quiet the moment rst drops.
    assign w_run  = rst;
    assign w_idle = w_run && (r_state == ST_IDLE);

    assign w_rd_ok = !bus.af_full && (r_tag_count != TAG_FULL_COUNT);
    assign w_wr_ok = !bus.af_full && !bus.wdf_full;

    assign w_rr_req = {bus.le_req, bus.ff_req, bus.gp_req};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_elig
            assign w_rr_elig[gi] = w_rr_req[gi] && (RR_IS_WRITE[gi] ? w_wr_ok : w_rd_ok);
        end
    endgenerate

    assign w_rr_idx1 = rr_add(r_rr_ptr, 2'd1);
    assign w_rr_idx2 = rr_add(r_rr_ptr, 2'd2);

    // First eligible client starting at the pointer wins.
    always_comb begin
        w_rr_hit = 1'b1;
        w_rr_win = r_rr_ptr;
        if (w_rr_elig[r_rr_ptr]) begin
            w_rr_win = r_rr_ptr;
        end else if (w_rr_elig[w_rr_idx1]) begin
            w_rr_win = w_rr_idx1;
        end else if (w_rr_elig[w_rr_idx2]) begin
            w_rr_win = w_rr_idx2;
        end else begin
            w_rr_hit = 1'b0;
        end
    end

    assign w_pf_go = w_idle && bus.pf_req && w_rd_ok;
    assign w_rr_go = w_idle && !w_pf_go && w_rr_hit;
    assign w_gp_go = w_rr_go && (w_rr_win == RR_GP);
    assign w_ff_go = w_rr_go && (w_rr_win == RR_FF);
    assign w_le_go = w_rr_go && (w_rr_win == RR_LE);
    assign w_wr_go = w_ff_go || w_le_go;
    assign w_push  = w_pf_go || w_gp_go;
    assign w_b1_go = w_run && (r_state == ST_WR_B1) && !bus.wdf_full;

    // Command issue to the address FIFO
    always_comb begin
        bus.af_wr_en    = w_push || w_wr_go;
        bus.af_cmd_din  = w_push ? CMD_READ : CMD_WRITE;
        bus.af_addr_din = '0;
        if (w_pf_go) begin
            bus.af_addr_din = bus.pf_addr;
        end else if (w_gp_go) begin
            bus.af_addr_din = bus.gp_addr;
        end else if (w_ff_go) begin
            bus.af_addr_din = bus.ff_addr;
        end else if (w_le_go) begin
            bus.af_addr_din = bus.le_addr;
        end
    end

    // Write data: low half on the grant cycle, high half from the latched writer in WR_B1.
    always_comb begin
        bus.wdf_wr_en    = 1'b0;
        bus.wdf_din      = '0;
        bus.wdf_mask_din = '0;
        if (w_ff_go) begin
            bus.wdf_wr_en    = 1'b1;
            bus.wdf_din      = bus.ff_wdata[127:0];
            bus.wdf_mask_din = bus.ff_wmask[15:0];
        end else if (w_le_go) begin
            bus.wdf_wr_en    = 1'b1;
            bus.wdf_din      = bus.le_wdata[127:0];
            bus.wdf_mask_din = bus.le_wmask[15:0];
        end else if (w_b1_go) begin
            bus.wdf_wr_en    = 1'b1;
            bus.wdf_din      = r_wr_id ? bus.le_wdata[255:128] : bus.ff_wdata[255:128];
            bus.wdf_mask_din = r_wr_id ? bus.le_wmask[31:16]   : bus.ff_wmask[31:16];
        end
    end

    assign bus.pf_ack = w_pf_go;
    assign bus.gp_ack = w_gp_go;
    assign bus.ff_ack = w_b1_go && !r_wr_id;
    assign bus.le_ack = w_b1_go &&  r_wr_id;

    // Read return path: purely combinational from the read-data FIFO head.
    assign w_rdf_pop   = w_run && bus.rdf_valid;
    assign w_tag_busy  = (r_tag_count != '0);
    assign w_tag_head  = r_tags[r_tag_rd_ptr];
    assign w_tag_pop   = w_rdf_pop && w_tag_busy && r_beat;

    assign bus.rdf_rd_en   = w_rdf_pop;
    assign bus.rd_data     = w_run ? bus.rdf_dout : '0;
    assign bus.pf_rd_valid = w_rdf_pop && w_tag_busy && !w_tag_head;
    assign bus.gp_rd_valid = w_rdf_pop && w_tag_busy &&  w_tag_head;
    assign o_orphan_err    = w_run && r_orphan;

    // Tag storage needs no reset: only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tags[r_tag_wr_ptr] <= w_gp_go;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_wr_ptr <= '0;
            r_tag_rd_ptr <= '0;
            r_tag_count  <= '0;
            r_beat       <= 1'b0;
            r_orphan     <= 1'b0;
        end else begin
            if (w_push) begin
                r_tag_wr_ptr <= r_tag_wr_ptr + 1'b1;
            end
            if (w_tag_pop) begin
                r_tag_rd_ptr <= r_tag_rd_ptr + 1'b1;
            end
            case ({w_push, w_tag_pop})
                2'b10:   r_tag_count <= r_tag_count + 1'b1;
                2'b01:   r_tag_count <= r_tag_count - 1'b1;
                default: r_tag_count <= r_tag_count;
            endcase
            if (w_rdf_pop && w_tag_busy) begin
                r_beat <= ~r_beat;
            end
            if (w_rdf_pop && !w_tag_busy) begin
                r_orphan <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= RR_GP;
            r_wr_id  <= 1'b0;
        end else begin
            if (w_rr_go) begin
                r_rr_ptr <= rr_add(w_rr_win, 2'd1);
            end
            if (w_wr_go) begin
                r_state <= ST_WR_B1;
                r_wr_id <= w_le_go;
            end else if (w_b1_go) begin
                r_state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed and randomized bench for dram_req_arbiter, checked every cycle against a
// queue-based reference model of the arbitration and read-steering rules.
module tb_dram_req_arbiter;
    localparam int TAG_DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic orphan_err;

    always #5 clk = ~clk;

    dram_req_arbiter_if bus();

    dram_req_arbiter #(.TAG_DEPTH(TAG_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .o_orphan_err (orphan_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: client indices 0=pf 1=gp 2=ff 3=le
    bit m_busy;
    int m_wr;
    int m_ptr;
    int tagq[$];
    bit m_beat;
    bit m_orphan;
    bit rand_mode = 1'b0;

    int ack_log[$];
    int rdv_log[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            chk(tag, (k < got.size()) ? got[k] : -1, exp[k]);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
        return v;
    endfunction

    task automatic new_req(input int c);
        case (c)
            0: begin bus.pf_req = 1'b1; bus.pf_addr = 31'($urandom); end
            1: begin bus.gp_req = 1'b1; bus.gp_addr = 31'($urandom); end
            2: begin bus.ff_req = 1'b1; bus.ff_addr = 31'($urandom);
                     bus.ff_wdata = rand256(); bus.ff_wmask = $urandom; end
            default: begin bus.le_req = 1'b1; bus.le_addr = 31'($urandom);
                     bus.le_wdata = rand256(); bus.le_wmask = $urandom; end
        endcase
    endtask

    function automatic bit req_of(input int c);
        case (c)
            0: return bus.pf_req;
            1: return bus.gp_req;
            2: return bus.ff_req;
            default: return bus.le_req;
        endcase
    endfunction

    function automatic logic [30:0] addr_of(input int c);
        case (c)
            0: return bus.pf_addr;
            1: return bus.gp_addr;
            2: return bus.ff_addr;
            default: return bus.le_addr;
        endcase
    endfunction

    // One clock: compare at the falling edge, advance the model, change inputs after the rising edge.
    task automatic cycle();
        logic         e_af_wr_en, e_wdf_wr_en, e_rdf_rd_en, e_orphan;
        logic [2:0]   e_af_cmd;
        logic [30:0]  e_af_addr;
        logic [127:0] e_wdf_din, e_rd_data;
        logic [15:0]  e_wdf_mask;
        logic [3:0]   e_ack;
        logic [1:0]   e_rdv;
        logic [255:0] wd;
        logic [31:0]  wm;
        bit rd_ok, wr_ok, b1;
        int win, c;

        @(negedge clk);
        e_af_wr_en = 0; e_wdf_wr_en = 0; e_rdf_rd_en = 0; e_orphan = 0;
        e_af_cmd = 0; e_af_addr = 0; e_wdf_din = 0; e_rd_data = 0; e_wdf_mask = 0;
        e_ack = 0; e_rdv = 0; win = -1; b1 = 0;
        if (rst) begin
            e_orphan  = m_orphan;
            e_rd_data = bus.rdf_dout;
            if (bus.rdf_valid) begin
                e_rdf_rd_en = 1;
                if (tagq.size() > 0) e_rdv[tagq[0]] = 1'b1;
            end
            rd_ok = !bus.af_full && (tagq.size() < TAG_DEPTH);
            wr_ok = !bus.af_full && !bus.wdf_full;
            if (!m_busy) begin
                if (bus.pf_req && rd_ok) win = 0;
                else begin
                    for (int k = 0; k < 3; k++) begin
                        c = (m_ptr + k) % 3 + 1;
                        if (win < 0 && req_of(c) && ((c == 1) ? rd_ok : wr_ok)) win = c;
                    end
                end
            end else if (!bus.wdf_full) begin
                b1 = 1;
            end
            if (win == 0 || win == 1) begin
                e_af_wr_en = 1; e_af_cmd = 3'b001; e_af_addr = addr_of(win); e_ack[win] = 1'b1;
            end else if (win >= 2) begin
                wd = (win == 2) ? bus.ff_wdata : bus.le_wdata;
                wm = (win == 2) ? bus.ff_wmask : bus.le_wmask;
                e_af_wr_en = 1; e_af_cmd = 3'b000; e_af_addr = addr_of(win);
                e_wdf_wr_en = 1; e_wdf_din = wd[127:0]; e_wdf_mask = wm[15:0];
            end
            if (b1) begin
                wd = (m_wr == 0) ? bus.ff_wdata : bus.le_wdata;
                wm = (m_wr == 0) ? bus.ff_wmask : bus.le_wmask;
                e_wdf_wr_en = 1; e_wdf_din = wd[255:128]; e_wdf_mask = wm[31:16];
                e_ack[2 + m_wr] = 1'b1;
            end
        end

        chk("af_wr_en", bus.af_wr_en, e_af_wr_en);
        chk("af_cmd_din", bus.af_cmd_din, e_af_cmd);
        chk("af_addr_din", bus.af_addr_din, e_af_addr);
        chk("wdf_wr_en", bus.wdf_wr_en, e_wdf_wr_en);
        chk("wdf_din", bus.wdf_din, e_wdf_din);
        chk("wdf_mask_din", bus.wdf_mask_din, e_wdf_mask);
        chk("acks", {bus.le_ack, bus.ff_ack, bus.gp_ack, bus.pf_ack}, e_ack);
        chk("rd_valid", {bus.gp_rd_valid, bus.pf_rd_valid}, e_rdv);
        chk("rdf_rd_en", bus.rdf_rd_en, e_rdf_rd_en);
        chk("rd_data", bus.rd_data, e_rd_data);
        chk("orphan_err", orphan_err, e_orphan);

        if (bus.pf_ack) ack_log.push_back(0);
        if (bus.gp_ack) ack_log.push_back(1);
        if (bus.ff_ack) ack_log.push_back(2);
        if (bus.le_ack) ack_log.push_back(3);
        if (bus.pf_rd_valid) rdv_log.push_back(0);
        if (bus.gp_rd_valid) rdv_log.push_back(1);

        if (!rst) begin
            m_busy = 0; m_wr = 0; m_ptr = 0; tagq.delete(); m_beat = 0; m_orphan = 0;
        end else begin
            if (bus.rdf_valid) begin
                if (tagq.size() > 0) begin
                    if (m_beat) void'(tagq.pop_front());
                    m_beat = !m_beat;
                end else begin
                    m_orphan = 1;
                end
            end
            if (win == 0 || win == 1) tagq.push_back(win);
            if (win >= 1) m_ptr = win % 3;
            if (win >= 2) begin m_busy = 1; m_wr = win - 2; end
            if (b1) m_busy = 0;
        end

        @(posedge clk);
        #1;
        if (e_ack[0]) bus.pf_req = 1'b0;
        if (e_ack[1]) bus.gp_req = 1'b0;
        if (e_ack[2]) bus.ff_req = 1'b0;
        if (e_ack[3]) bus.le_req = 1'b0;
        if (rand_mode) begin
            for (int k = 0; k < 4; k++) begin
                if (!req_of(k) && ($urandom % 3 == 0)) new_req(k);
            end
        end
    endtask

    task automatic clear_reqs();
        bus.pf_req = 0; bus.gp_req = 0; bus.ff_req = 0; bus.le_req = 0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * TAG_DEPTH && tagq.size() > 0; i++) begin
            bus.rdf_valid = 1'b1;
            bus.rdf_dout  = rand256()[127:0];
            cycle();
        end
        bus.rdf_valid = 1'b0;
    endtask

    initial begin
        clear_reqs();
        bus.pf_addr = 0; bus.gp_addr = 0; bus.ff_addr = 0; bus.le_addr = 0;
        bus.ff_wdata = 0; bus.le_wdata = 0; bus.ff_wmask = 0; bus.le_wmask = 0;
        bus.af_full = 0; bus.wdf_full = 0; bus.rdf_valid = 0; bus.rdf_dout = 0;
        m_busy = 0; m_wr = 0; m_ptr = 0; m_beat = 0; m_orphan = 0;

        // Reset held with live inputs: everything must stay quiet
        @(posedge clk); #1;
        bus.gp_req = 1; bus.rdf_valid = 1; bus.rdf_dout = 128'hdead;
        cycle();
        cycle();
        clear_reqs(); bus.rdf_valid = 0;
        rst = 1'b1;

        // Reset in the middle of WR_B1, then a read at 0x100
        new_req(2);
        cycle();
        rst = 1'b0;
        clear_reqs();
        cycle();
        rst = 1'b1;
        ack_log.delete();
        bus.gp_req = 1; bus.gp_addr = 31'h100;
        cycle();
        chk_log("rst_gp_ack", ack_log, '{1});
        drain();

        // Round robin gp -> ff -> le
        do_reset();
        ack_log.delete();
        for (int i = 0; i < 40 && ack_log.size() < 6; i++) begin
            for (int k = 1; k < 4; k++) if (!req_of(k)) new_req(k);
            cycle();
        end
        clear_reqs();
        chk_log("rr_order", ack_log, '{1, 2, 3, 1, 2, 3});
        drain();

        // pf beats ff from IDLE
        ack_log.delete();
        new_req(0); new_req(2);
        for (int i = 0; i < 3; i++) cycle();
        chk_log("pf_first", ack_log, '{0, 2});

        // Continuous pf starves gp
        ack_log.delete();
        new_req(1);
        for (int i = 0; i < 5; i++) begin new_req(0); cycle(); end
        cycle();
        chk_log("pf_starve", ack_log, '{0, 0, 0, 0, 0, 1});
        drain();

        // Read return steering
        rdv_log.delete();
        bus.pf_req = 1; bus.pf_addr = 31'h10; cycle();
        bus.gp_req = 1; bus.gp_addr = 31'h20; cycle();
        bus.pf_req = 1; bus.pf_addr = 31'h30; cycle();
        for (int i = 0; i < 6; i++) begin
            bus.rdf_valid = 1; bus.rdf_dout = {32'(i), 96'h0} | 128'h5a5a; cycle();
        end
        bus.rdf_valid = 0;
        chk_log("steer", rdv_log, '{0, 0, 1, 1, 0, 0});

        // wdf_full stalls WR_B1 for exactly 3 cycles
        ack_log.delete();
        new_req(2);
        cycle();
        bus.wdf_full = 1;
        for (int i = 0; i < 3; i++) cycle();
        chk("wdf_stall_no_ack", ack_log.size(), 0);
        bus.wdf_full = 0;
        cycle();
        chk_log("wdf_stall_ack", ack_log, '{2});

        // af_full blocks all issue
        ack_log.delete();
        bus.af_full = 1;
        new_req(1); new_req(3);
        for (int i = 0; i < 3; i++) cycle();
        chk("af_full_block", ack_log.size(), 0);
        bus.af_full = 0;
        for (int i = 0; i < 10 && ack_log.size() < 2; i++) cycle();
        chk("af_full_release", ack_log.size(), 2);
        drain();

        // Ninth read stalls until a full two-beat return has popped a tag
        ack_log.delete();
        for (int i = 0; i < TAG_DEPTH + 1; i++) begin
            if (!bus.pf_req) new_req(0);
            cycle();
        end
        chk("tag_full_count", ack_log.size(), TAG_DEPTH);
        bus.rdf_valid = 1;
        cycle();
        cycle();
        bus.rdf_valid = 0;
        chk("tag_full_pop_cycle", ack_log.size(), TAG_DEPTH);
        cycle();
        chk("tag_full_release", ack_log.size(), TAG_DEPTH + 1);
        drain();

        // Orphan beat sets a sticky flag
        chk("orphan_clear", orphan_err, 1'b0);
        bus.rdf_valid = 1; bus.rdf_dout = 128'hbeef;
        cycle();
        bus.rdf_valid = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("orphan_sticky", orphan_err, 1'b1);
        do_reset();
        chk("orphan_reset", orphan_err, 1'b0);

        // Randomized traffic against the model
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.af_full   = ($urandom % 5 == 0);
            bus.wdf_full  = ($urandom % 4 == 0);
            bus.rdf_valid = (tagq.size() > 0) && ($urandom % 2 == 0);
            bus.rdf_dout  = rand256()[127:0];
            cycle();
        end
        rand_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dram_req_arbiter.md
# dram_req_arbiter

Shares the single DRAM request-controller port (address FIFO, write-data FIFO, read-data FIFO) among four clients: pixel feeder (read), graphics processor command fetch (read), frame filler (write) and line engine (write). It sits between those engines and the DRAM controller. It serializes commands, emits the two-beat write bursts, and steers returning read beats to the client that issued each read, using an in-order tag queue.

## Interface
Parameters:
- TAG_DEPTH, 8: maximum outstanding reads (power of two, ≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pf_req / gp_req  in  1  read request; held until matching ack.
- pf_addr / gp_addr  in  31  read burst address.
- pf_ack / gp_ack  out  1  one-cycle pulse when the read command is issued.
- pf_rd_valid / gp_rd_valid  out  1  read beat valid for that client; no backpressure.
- rd_data  out  128  shared read-beat data (rdf_dout passthrough).
- ff_req / le_req  in  1  write request; req, addr, data and mask held until ack.
- ff_addr / le_addr  in  31  write burst address.
- ff_wdata / le_wdata  in  256  burst data, [127:0] is beat 0.
- ff_wmask / le_wmask  in  32  byte mask (1 = masked), [15:0] is beat 0.
- ff_ack / le_ack  out  1  one-cycle pulse when beat 1 is written.
- af_full  in  1  address FIFO full.
- af_wr_en  out  1  address FIFO push.
- af_addr_din  out  31  command address.
- af_cmd_din  out  3  3'b000 write, 3'b001 read.
- wdf_full  in  1  write-data FIFO full.
- wdf_wr_en  out  1  write-data push.
- wdf_din  out  128  write beat.
- wdf_mask_din  out  16  write beat mask.
- rdf_valid  in  1  read-data FIFO non-empty.
- rdf_dout  in  128  read-data head.
- rdf_rd_en  out  1  read-data pop.
- orphan_err  out  1  sticky flag: read beat arrived with no tag outstanding.

## Operation
- States: IDLE, WR_B1.
- **Arbitration** happens in IDLE each cycle:
  - pf has absolute priority.
  - gp, ff and le are round-robin in the order gp→ff→le→gp. The pointer advances to the client after the winner on each grant.
- **Read eligibility:** a read is eligible only if af_full=0 and the tag queue is not full.
- **Write eligibility:** a write is eligible only if af_full=0 and wdf_full=0.
- Ineligible requesters are skipped; the pointer is not moved by them.
- **Read grant** (IDLE, same cycle):
  - af_wr_en=1, af_cmd_din=001, af_addr_din=addr.
  - The client's ack pulses.
  - The tag is pushed: 0=pf, 1=gp.
  - State stays IDLE.
- **Write grant** (IDLE cycle):
  - af_wr_en=1, af_cmd_din=000.
  - wdf_wr_en=1, wdf_din=wdata[127:0], wdf_mask_din=wmask[15:0].
  - Writer id is latched; go to WR_B1.
- **WR_B1:**
  - If wdf_full=0: wdf_wr_en=1 with wdata[255:128] and wmask[31:16], pulse that writer's ack, return to IDLE.
  - Otherwise hold in WR_B1 with all strobes low.
- **Read return** is independent of the issue path:
  - When rdf_valid=1: rdf_rd_en=1 and rd_data=rdf_dout.
  - If the queue is non-empty, assert the head tag's rd_valid and toggle the beat bit.
  - On the second beat, pop the tag.
  - If the queue is empty, still pop the rdf, drop the beat, and set orphan_err.
- **Queue occupancy:** a push and a pop in the same cycle leave the count unchanged. The full check uses the pre-cycle count.
- Address and data pass through unmodified. No bursts are split or merged.

## Timing
- **Reset values:** all outputs 0, state IDLE, pointer at gp, tag queue empty, beat bit 0, orphan_err 0.
- **Reset mid-burst:** the arbiter aborts immediately. The DRAM controller FIFOs must be reset in the same reset domain.
- **Read issue latency:** req high in an IDLE cycle with eligibility → af_wr_en and ack in that same cycle (combinational grant, registered state).
- **Write latency:** 2 cycles minimum (IDLE, WR_B1). Ack arrives in the second cycle. Each wdf_full=1 cycle in WR_B1 adds one cycle.
- **Back-to-back commands:** reads can issue every cycle. After a write, the next grant can happen in the cycle after WR_B1.
- **Tags in flight:** at most TAG_DEPTH. Once full, further reads stall even if a pop occurs in that cycle.
- **Read-beat delivery:** rd_valid and rd_data are combinational from rdf_valid and rdf_dout, which gives zero added latency.

## Test plan
- **Reset:** assert rst=0 mid-WR_B1 → all outputs 0 immediately; after release, first gp_req at addr 0x100 → af_wr_en, af_cmd_din=001, gp_ack in the same cycle.
- **Round-robin:** hold gp, ff and le requests continuously with af/wdf never full → grant order gp, ff, le, gp, ff, le. Each write shows two wdf beats with the correct halves and masks.
- **pf priority:** pf_req and ff_req asserted together from IDLE → pf is granted first, ff in the next cycle; pf asserted every cycle starves the others.
- **Read return steering:** issue pf@0x10, gp@0x20, pf@0x30, then return 6 rdf beats → pf_rd_valid on beats 1–2, gp_rd_valid on 3–4, pf_rd_valid on 5–6, with rd_data matching rdf_dout.
- **Full conditions:**
  - Wdf_full=1 during WR_B1 for 3 cycles → beat 1 and ack are delayed exactly 3 cycles.
  - af_full=1 → no af_wr_en.
  - After 8 un-returned reads → the 9th read stalls until 2 beats return.
- **Orphan:** rdf_valid=1 with an empty tag queue → rdf_rd_en=1, no rd_valid, orphan_err=1 and stays set until reset.
